// File: rtl/key_pkg.sv
// key_pkg: shared default constants and helpers for the key debounce slice.
package key_pkg;

    localparam int unsigned KEY_DEB_CNT_DEFAULT  = 500_000;
    localparam int unsigned KEY_LONG_CNT_DEFAULT = 50_000_000;
    localparam int unsigned KEY_NUM_DEFAULT      = 4;

    // Bit width of a counter that must represent every value 0..max_val.
    function automatic int unsigned key_cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel -- 2-flop synchroniser, debounce counter,
// debounced level with press/release pulses, and (when KEY_LONG_PRESS_EN is
// defined) a saturating long-press counter with a one-shot key_long pulse.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX    = KEY_DEB_CNT_DEFAULT,
    parameter int unsigned LONG_MAX   = KEY_LONG_CNT_DEFAULT,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_state,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int unsigned   CW         = key_cnt_width(CNT_MAX);
    localparam logic [CW-1:0] C_DEB_LAST = CW'(CNT_MAX - 1);
    // Raw pin level of a released key.
    localparam logic          C_IDLE_PIN = (ACTIVE_LOW != 0);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_state;
    logic          r_press;
    logic          r_release;
    logic [CW-1:0] r_deb_cnt;

    logic w_level;
    logic w_differs;
    logic w_toggle;

    assign w_level   = r_sync2 ^ C_IDLE_PIN;
    assign w_differs = (w_level != r_state);
    assign w_toggle  = w_differs && (r_deb_cnt == C_DEB_LAST);

    // Synchroniser, preloaded with the released level so reset never looks like a press.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= C_IDLE_PIN;
            r_sync2 <= C_IDLE_PIN;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: count consecutive mismatches; flip the level and pulse on the last one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_deb_cnt <= '0;
            r_state   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_toggle && !r_state;
            r_release <= w_toggle &&  r_state;
            if (w_toggle) begin
                r_state   <= !r_state;
                r_deb_cnt <= '0;
            end else if (w_differs) begin
                r_deb_cnt <= r_deb_cnt + CW'(1);
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    assign o_state   = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned   LW          = key_cnt_width(LONG_MAX);
    localparam logic [LW-1:0] C_LONG_MAX  = LW'(LONG_MAX);
    localparam logic [LW-1:0] C_LONG_LAST = LW'(LONG_MAX - 1);

    logic [LW-1:0] r_long_cnt;
    logic          r_long;

    // Long-press counter: runs while pressed, saturates at the threshold, clears on release.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_long_cnt <= '0;
            r_long     <= 1'b0;
        end else begin
            r_long <= r_state && (r_long_cnt == C_LONG_LAST);
            if (!r_state) begin
                r_long_cnt <= '0;
            end else if (r_long_cnt != C_LONG_MAX) begin
                r_long_cnt <= r_long_cnt + LW'(1);
            end
        end
    end

    assign o_long = r_long;
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: rtl/key_multi_debounce.sv
// key_multi_debounce: NUM_KEYS independent debounced key channels.
// Optional long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_multi_debounce
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = KEY_NUM_DEFAULT,
    parameter int unsigned CNT_MAX    = KEY_DEB_CNT_DEFAULT,
    parameter int unsigned LONG_MAX   = KEY_LONG_CNT_DEFAULT,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    // One self-contained channel per key pin.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX    (CNT_MAX),
            .LONG_MAX   (LONG_MAX),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_key     (key_in[g]),
            .o_state   (key_state[g]),
            .o_press   (key_press[g]),
            .o_release (key_release[g]),
            .o_long    (key_long[g])
        );
    end

endmodule

// File: doc/key_multi_debounce.md
KEY_MULTI_DEBOUNCE -- requirements
Module: key_multi_debounce

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of independent key channels, range 1..32.
REQ-002 SHALL have parameter CNT_MAX, default 500_000: debounce interval in clk cycles, 10 ms at 50 MHz, minimum 2.
REQ-003 SHALL have parameter LONG_MAX, default 50_000_000: long-press threshold in clk cycles, 1 s at 50 MHz, greater than CNT_MAX.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 = key pressed when pin low; 0 = pressed when high.
REQ-005 SHALL have port clk, input, 1: the single system clock.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port key_in, input, NUM_KEYS: raw asynchronous key pins.
REQ-008 SHALL have port key_state, output, NUM_KEYS: debounced level, 1 = pressed, independent of ACTIVE_LOW.
REQ-009 SHALL have port key_press, output, NUM_KEYS: one-cycle pulse on a debounced press.
REQ-010 SHALL have port key_release, output, NUM_KEYS: one-cycle pulse on a debounced release.
REQ-011 SHALL have port key_long, output, NUM_KEYS: one-cycle pulse when a press has lasted LONG_MAX cycles.

Function
REQ-012 SHALL pass each key_in bit through a 2-flop synchroniser, then normalise it to pressed=1 per ACTIVE_LOW.
REQ-013 SHALL give each channel a debounce counter of width clog2(CNT_MAX+1).
- Counter clears when the synchronised level equals key_state.
- Counter increments by 1 when the level differs.
REQ-014 SHALL act on the edge where the counter equals CNT_MAX-1 and the level still differs:
- toggle key_state;
- clear the counter;
- assert key_press (new state 1) or key_release (new state 0) for exactly that one cycle.
REQ-015 SHALL update key_state and issue the pulse exactly CNT_MAX+2 clk edges after the first edge that samples a new stable pin level. This latency is fixed.
REQ-016 SHALL ignore a glitch that holds for fewer than CNT_MAX synchronised cycles: no state change, no pulse, and the counter restarts from 0 on the next mismatch.
REQ-017 SHALL debounce channels fully independently. Simultaneous transitions on several channels produce simultaneous pulses in the same cycle.
REQ-018 SHALL never assert key_press and key_release together on one channel, and SHALL pulse at most once per debounced transition.
REQ-019 SHALL give each channel a long-press counter of width clog2(LONG_MAX+1):
- counts while key_state=1;
- saturates at LONG_MAX;
- clears when key_state=0.
REQ-020 SHALL pulse key_long for one cycle on the edge the long counter reaches LONG_MAX. There is exactly one key_long per press, and none after release.

Reset
REQ-021 SHALL, while rst=1 at a clk edge, clear all counters and set key_state, key_press, key_release and key_long to 0.
REQ-022 SHALL load the synchroniser flops with the released pin level during reset, so no spurious pulse follows reset.
REQ-023 SHALL abort any in-progress debounce or long-press count when reset is asserted mid-operation. A key still held when rst deasserts produces key_press CNT_MAX+2 cycles later.

Configuration
REQ-024 SHALL compile long-press logic only when macro KEY_LONG_PRESS_EN is defined.
- Without the macro: key_long is tied to 0, no long counters are built, and LONG_MAX is unused.
- Debounce behaviour is identical with and without the macro.

Structure
REQ-025 SHALL take default constants from shared package key_pkg:
- KEY_DEB_CNT_DEFAULT = 500_000;
- KEY_LONG_CNT_DEFAULT = 50_000_000;
- KEY_NUM_DEFAULT = 4.
REQ-026 SHALL implement one channel (synchroniser, debounce counter, long counter, pulse regs) as sub-module key_debounce_ch, instantiated NUM_KEYS times in a generate loop.

Verification
Bench parameters: NUM_KEYS=4, CNT_MAX=8, LONG_MAX=20, ACTIVE_LOW=1, macro defined.
REQ-027 SHALL test a clean press: key_in[0] 1->0 held -> key_state[0]=1 and a one-cycle key_press[0] exactly 10 cycles after the first low sample.
REQ-028 SHALL test bounce: key_in[1] low for 5 cycles, high for 2, then low held -> a single key_press[1], 10 cycles after the final low, with no earlier pulse.
REQ-029 SHALL test long press: key_in[2] held low 40 cycles -> key_press[2], then one key_long[2] 20 cycles later, then no further key_long.
REQ-030 SHALL test release: after REQ-029, key_in[2] back high -> key_release[2] 10 cycles later, key_state[2]=0, long counter cleared.
REQ-031 SHALL test simultaneity and reset: key_in[3:0]=0000 at one edge -> key_press=1111 in the same cycle. Then rst=1 for 3 cycles with keys held low -> all outputs 0, and key_press=1111 again 10 cycles after rst falls.
REQ-032 SHALL test the macro off: build without KEY_LONG_PRESS_EN, hold key_in[0] low 100 cycles -> key_long=0 throughout, and press timing unchanged.
